// File: rtl/jump_target_unit_pkg.sv
// rtl/jump_target_unit_pkg.sv - shared mode encodings and default sizes for the jump target unit
package jump_target_unit_pkg;

    localparam int DEF_ADDR_W    = 32;
    localparam int DEF_RAS_DEPTH = 4;

    // Fetch-stage control-flow class of the instruction being resolved
    typedef enum logic [1:0] {
        MODE_SEQ = 2'b00,
        MODE_J   = 2'b01,
        MODE_JAL = 2'b10,
        MODE_RET = 2'b11
    } jtu_mode_e;

endpackage

// File: rtl/jtu_ras.sv
// rtl/jtu_ras.sv - circular return-address stack with saturating occupancy count
module jtu_ras
    import jump_target_unit_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int RAS_DEPTH = DEF_RAS_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic              empty,
    output logic              full
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

    logic [ADDR_W-1:0] mem [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_nxt;

    // ptr names the next free slot, so the newest entry sits one below it
    assign top = mem[ptr - PTR_W'(1)];

    // Occupancy saturates at depth on push and never goes below zero on pop
    always_comb begin
        count_nxt = count;
        if (push && (count != CNT_MAX)) begin
            count_nxt = count + CNT_W'(1);
        end else if (pop && (count != '0)) begin
            count_nxt = count - CNT_W'(1);
        end
    end

    // Pointer, count and registered empty/full flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr   <= '0;
            count <= '0;
            empty <= 1'b1;
            full  <= 1'b0;
        end else begin
            if (push) begin
                ptr <= ptr + PTR_W'(1);
            end else if (pop && (count != '0)) begin
                ptr <= ptr - PTR_W'(1);
            end
            count <= count_nxt;
            empty <= (count_nxt == '0);
            full  <= (count_nxt == CNT_MAX);
        end
    end

    // Entry storage; writing at ptr when full lands on the oldest entry
    always_ff @(posedge clk) begin
        if (push) begin
            mem[ptr] <= push_data;
        end
    end

endmodule

// File: rtl/jump_target_unit.sv
// rtl/jump_target_unit.sv - J/JAL/RET next-fetch target resolution with return-address stack
module jump_target_unit
    import jump_target_unit_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int RAS_DEPTH = DEF_RAS_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [1:0]        in_mode,
    input  logic [25:0]       in_instr_index,
    input  logic [ADDR_W-1:0] in_pc_plus4,
    input  logic              in_stall,
    input  logic              in_flush,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_target,
    output logic              out_taken,
    output logic              out_ras_empty,
    output logic              out_ras_full,
    output logic              out_ras_underflow
);

    jtu_mode_e         mode;
    logic              accept;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] ras_top;
    logic [ADDR_W-1:0] next_target;
    logic              next_taken;

    assign mode   = jtu_mode_e'(in_mode);
    assign accept = in_valid && !in_stall && !in_flush;
    assign push   = accept && (mode == MODE_JAL);
    assign pop    = accept && (mode == MODE_RET) && !out_ras_empty;

    jtu_ras #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .push_data (in_pc_plus4 + ADDR_W'(4)),
        .top       (ras_top),
        .empty     (out_ras_empty),
        .full      (out_ras_full)
    );

    // Target select: region jump keeps the upper PC bits, RET falls through when the stack is empty
    always_comb begin
        next_target = in_pc_plus4;
        next_taken  = 1'b0;
        case (mode)
            MODE_J, MODE_JAL: begin
                next_target[27:0] = {in_instr_index, 2'b00};
                next_taken        = 1'b1;
            end
            MODE_RET: begin
                if (!out_ras_empty) begin
                    next_target = ras_top;
                    next_taken  = 1'b1;
                end
            end
            default: begin
                next_taken = 1'b0;
            end
        endcase
    end

    // Output register: flush beats stall, a bubble clears valid/taken but keeps the last target
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid         <= 1'b0;
            out_target        <= '0;
            out_taken         <= 1'b0;
            out_ras_underflow <= 1'b0;
        end else begin
            out_ras_underflow <= accept && (mode == MODE_RET) && out_ras_empty;
            if (in_flush || (!in_stall && !in_valid)) begin
                out_valid <= 1'b0;
                out_taken <= 1'b0;
            end else if (accept) begin
                out_valid  <= 1'b1;
                out_target <= next_target;
                out_taken  <= next_taken;
            end
        end
    end

endmodule

// File: tb/tb_jump_target_unit.sv
// tb/tb_jump_target_unit.sv - randomized model-checked bench for jump_target_unit
module tb_jump_target_unit;
    import jump_target_unit_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [1:0]  in_mode;
    logic [25:0] in_instr_index;
    logic [31:0] in_pc_plus4;
    logic        in_stall;
    logic        in_flush;
    logic        out_valid;
    logic [31:0] out_target;
    logic        out_taken;
    logic        out_ras_empty;
    logic        out_ras_full;
    logic        out_ras_underflow;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [31:0] stk[$];
    logic        m_valid = 1'b0;
    logic [31:0] m_target = 32'h0;
    logic        m_taken = 1'b0;
    logic        m_under = 1'b0;

    jump_target_unit #(
        .ADDR_W    (32),
        .RAS_DEPTH (DEPTH)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_valid          (in_valid),
        .in_mode           (in_mode),
        .in_instr_index    (in_instr_index),
        .in_pc_plus4       (in_pc_plus4),
        .in_stall          (in_stall),
        .in_flush          (in_flush),
        .out_valid         (out_valid),
        .out_target        (out_target),
        .out_taken         (out_taken),
        .out_ras_empty     (out_ras_empty),
        .out_ras_full      (out_ras_full),
        .out_ras_underflow (out_ras_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: stack as a bounded queue, newest at the back
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid  = 1'b0;
            m_target = 32'h0;
            m_taken  = 1'b0;
            m_under  = 1'b0;
            stk.delete();
        end else begin
            m_under = 1'b0;
            if (in_flush || (!in_stall && !in_valid)) begin
                m_valid = 1'b0;
                m_taken = 1'b0;
            end else if (!in_stall) begin
                m_valid = 1'b1;
                case (in_mode)
                    MODE_J: begin
                        m_target = {in_pc_plus4[31:28], in_instr_index, 2'b00};
                        m_taken  = 1'b1;
                    end
                    MODE_JAL: begin
                        m_target = {in_pc_plus4[31:28], in_instr_index, 2'b00};
                        m_taken  = 1'b1;
                        stk.push_back(in_pc_plus4 + 32'd4);
                        if (stk.size() > DEPTH) void'(stk.pop_front());
                    end
                    MODE_RET: begin
                        if (stk.size() > 0) begin
                            m_target = stk.pop_back();
                            m_taken  = 1'b1;
                        end else begin
                            m_target = in_pc_plus4;
                            m_taken  = 1'b0;
                            m_under  = 1'b1;
                        end
                    end
                    default: begin
                        m_target = in_pc_plus4;
                        m_taken  = 1'b0;
                    end
                endcase
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("valid", {63'b0, out_valid}, {63'b0, m_valid});
            chk("target", {32'b0, out_target}, {32'b0, m_target});
            chk("taken", {63'b0, out_taken}, {63'b0, m_taken});
            chk("underflow", {63'b0, out_ras_underflow}, {63'b0, m_under});
            chk("empty", {63'b0, out_ras_empty}, {63'b0, stk.size() == 0});
            chk("full", {63'b0, out_ras_full}, {63'b0, stk.size() == DEPTH});
        end
    end

    task automatic drive(input logic v, input logic [1:0] m, input logic [25:0] idx,
                         input logic [31:0] pc, input logic st, input logic fl);
        in_valid       = v;
        in_mode        = m;
        in_instr_index = idx;
        in_pc_plus4    = pc;
        in_stall       = st;
        in_flush       = fl;
        @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_valid"}, {63'b0, out_valid}, 64'd0);
        chk({tag, "_target"}, {32'b0, out_target}, 64'd0);
        chk({tag, "_taken"}, {63'b0, out_taken}, 64'd0);
        chk({tag, "_under"}, {63'b0, out_ras_underflow}, 64'd0);
        chk({tag, "_empty"}, {63'b0, out_ras_empty}, 64'd1);
        chk({tag, "_full"}, {63'b0, out_ras_full}, 64'd0);
    endtask

    // Asserts reset between edges and checks it takes effect without a clock
    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals(tag);
        in_valid = 1'b0;
        in_stall = 1'b0;
        in_flush = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] pc;
        rst_n          = 1'b0;
        in_valid       = 1'b0;
        in_mode        = 2'b00;
        in_instr_index = 26'h0;
        in_pc_plus4    = 32'h0;
        in_stall       = 1'b0;
        in_flush       = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset_vals("rst");
        rst_n = 1'b1;

        // Region jump with literal target
        drive(1, MODE_J, 26'h0123456, 32'hA000_0010, 0, 0);
        chk("j_target", {32'b0, out_target}, 64'hA048_D158);
        chk("j_taken", {63'b0, out_taken}, 64'd1);
        chk("j_valid", {63'b0, out_valid}, 64'd1);

        // JAL then RET returns link = pc_plus4 + 4
        drive(1, MODE_JAL, 26'h0000100, 32'h0040_0020, 0, 0);
        drive(1, MODE_RET, 26'h0, 32'h0050_0000, 0, 0);
        chk("ret_target", {32'b0, out_target}, 64'h0040_0024);
        chk("ret_taken", {63'b0, out_taken}, 64'd1);
        chk("ret_empty", {63'b0, out_ras_empty}, 64'd1);

        // Five pushes overflow a four-deep stack; the oldest link is lost
        for (int i = 1; i <= 5; i++) begin
            drive(1, MODE_JAL, 26'(i), 32'h1000_0000 + 32'(i * 16), 0, 0);
            if (i == 4) chk("full_after4", {63'b0, out_ras_full}, 64'd1);
        end
        for (int i = 5; i >= 2; i--) begin
            drive(1, MODE_RET, 26'h0, 32'h2000_0000, 0, 0);
            chk("ret_lifo", {32'b0, out_target}, {32'b0, 32'h1000_0004 + 32'(i * 16)});
        end
        drive(1, MODE_RET, 26'h0, 32'h3000_0040, 0, 0);
        chk("uf_taken", {63'b0, out_taken}, 64'd0);
        chk("uf_target", {32'b0, out_target}, 64'h3000_0040);
        chk("uf_pulse", {63'b0, out_ras_underflow}, 64'd1);
        drive(1, MODE_SEQ, 26'h0, 32'h3000_0044, 0, 0);
        chk("uf_clear", {63'b0, out_ras_underflow}, 64'd0);

        // Stall holds everything; flush with stall drops valid but keeps the stack
        drive(1, MODE_JAL, 26'h0000200, 32'h0000_1000, 0, 0);
        drive(1, MODE_J, 26'h0000abc, 32'h5000_0000, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 2'(i + 1), 26'($urandom), $urandom, 1, 0);
            chk("stall_target", {32'b0, out_target}, 64'h5000_2AF0);
            chk("stall_taken", {63'b0, out_taken}, 64'd1);
            chk("stall_empty", {63'b0, out_ras_empty}, 64'd0);
        end
        drive(1, MODE_RET, 26'h0, 32'h0, 1, 1);
        chk("flush_valid", {63'b0, out_valid}, 64'd0);
        chk("flush_target", {32'b0, out_target}, 64'h5000_2AF0);
        chk("flush_empty", {63'b0, out_ras_empty}, 64'd0);

        // Reset mid-operation wipes a partly filled stack
        drive(1, MODE_JAL, 26'h1, 32'h0000_2000, 0, 0);
        async_reset("mid_rst");
        drive(1, MODE_RET, 26'h0, 32'h0000_3000, 0, 0);
        chk("rst_ret_uf", {63'b0, out_ras_underflow}, 64'd1);
        chk("rst_ret_target", {32'b0, out_target}, 64'h0000_3000);

        // Randomized traffic, biased toward stack activity
        for (int n = 0; n < 3000; n++) begin
            pc = $urandom;
            if ($urandom_range(0, 399) == 0) begin
                async_reset("rnd_rst");
            end else begin
                drive($urandom_range(0, 99) < 85, 2'($urandom_range(0, 3)), 26'($urandom),
                      pc, $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 5);
            end
        end

        drive(0, MODE_SEQ, 26'h0, 32'h0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/jump_target_unit.md
JUMP_TARGET_UNIT -- requirements
Module: jump_target_unit

Interface
REQ-001 Parameter ADDR_W, default 32: PC/target width; SHALL be >= 28.
REQ-002 Parameter RAS_DEPTH, default 4: return-address stack entries; SHALL be a power of two >= 2.
REQ-003 clk  input  1  single clock; all state on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  fetch-stage instruction present.
REQ-006 in_mode  input  2  00 SEQ, 01 J, 10 JAL (push link), 11 RET (pop).
REQ-007 in_instr_index  input  26  instruction bits [25:0].
REQ-008 in_pc_plus4  input  ADDR_W  PC+4 of the instruction.
REQ-009 in_stall  input  1  hold stage.
REQ-010 in_flush  input  1  discard stage contents.
REQ-011 out_valid  output  1  registered result valid.
REQ-012 out_target  output  ADDR_W  next-fetch address.
REQ-013 out_taken  output  1  redirect required.
REQ-014 out_ras_empty  output  1  stack holds 0 entries.
REQ-015 out_ras_full  output  1  stack holds RAS_DEPTH entries.
REQ-016 out_ras_underflow  output  1  one-cycle pulse: RET on empty stack.

Function
REQ-017 Latency SHALL be exactly 1 cycle: accepted input appears on outputs after the next rising edge.
REQ-018 Input accepted when in_valid=1, in_stall=0, in_flush=0; only accepted inputs update stack or output register.
REQ-019 J/JAL target SHALL be {in_pc_plus4[ADDR_W-1:28], in_instr_index, 2'b00}; out_taken=1.
REQ-020 JAL SHALL push link = in_pc_plus4 + 4 (delay-slot skip), modulo 2^ADDR_W.
REQ-021 RET on non-empty stack: target = top entry, pop, out_taken=1.
REQ-022 RET on empty stack: target = in_pc_plus4, out_taken=0, out_ras_underflow=1 one cycle, stack unchanged.
REQ-023 SEQ: target = in_pc_plus4, out_taken=0.
REQ-024 Push when full SHALL overwrite oldest entry (circular pointer wrap); count saturates at RAS_DEPTH; out_ras_full stays 1.
REQ-025 Stall (flush=0): output register, stack and underflow hold except underflow clears to 0.
REQ-026 Flush has priority over stall: out_valid=0, out_taken=0 next cycle; stack unchanged; out_target holds.
REQ-027 in_valid=0 without stall/flush: out_valid=0, out_taken=0 next cycle.
REQ-028 out_ras_empty/out_ras_full SHALL be registered, derived from count, valid in the cycle after the update.

Reset
REQ-029 rst_n low SHALL immediately force out_valid=0, out_target=0, out_taken=0, out_ras_underflow=0, out_ras_empty=1, out_ras_full=0, count=0, pointer=0.
REQ-030 Reset mid-operation discards all stack contents and any pending result; first accept after release behaves as from empty.
REQ-031 Stack entry storage need not be reset.

Structure
REQ-032 Shared package SHALL hold mode encodings (SEQ/J/JAL/RET) and default ADDR_W, RAS_DEPTH.
REQ-033 Stack SHALL be one sub-module jtu_ras (push, pop, top, empty, full, circular pointer and saturating count); target mux and output register in jump_target_unit.

Verification (ADDR_W=32, RAS_DEPTH=4)
REQ-034 J, pc_plus4=0xA000_0010, index=0x0123456 -> next cycle out_valid=1, out_taken=1, out_target=0xA048_D158.
REQ-035 JAL pc_plus4=0x0040_0020, then RET -> RET result out_target=0x0040_0024, out_taken=1, out_ras_empty=1 afterwards.
REQ-036 Five JALs with links L1..L5, then five RETs -> full=1 after 4th push; RETs return L5,L4,L3,L2; 5th RET: out_taken=0, target=its pc_plus4, underflow=1 one cycle.
REQ-037 Accept J, then stall 3 cycles with varying inputs -> outputs and stack constant; stall+flush same cycle -> out_valid=0 next cycle, stack unchanged.
REQ-038 Push 2 entries, pull rst_n low between edges -> outputs at reset values without clock edge; after release, RET -> underflow=1.
